// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state encoding for the vote tally engine
package vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_TALLY  = 2'd2,
    ST_RESULT = 2'd3
  } vote_state_t;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_OPEN   = 2'd1;
  localparam logic [1:0] STATE_TALLY  = 2'd2;
  localparam logic [1:0] STATE_RESULT = 2'd3;

endpackage

// File: rtl/vote_max_scan.sv
// rtl/vote_max_scan.sv - sequential arg-max/tie scanner, one candidate per cycle
module vote_max_scan #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 12,
  localparam int IDX_W = $clog2(N_CAND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [IDX_W-1:0] idx,
  output logic             done,
  output logic [IDX_W-1:0] argmax,
  output logic [CNT_W-1:0] max_val,
  output logic             tie
);

  logic busy;

  assign done = busy && (idx == IDX_W'(N_CAND - 1));

  // Strict > keeps the lowest index; equality with a zero max is filtered by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      idx     <= '0;
      argmax  <= '0;
      max_val <= '0;
      tie     <= 1'b0;
    end else if (clear || start) begin
      busy    <= start && !clear;
      idx     <= '0;
      argmax  <= '0;
      max_val <= '0;
      tie     <= 1'b0;
    end else if (busy) begin
      if (cnt_in > max_val) begin
        max_val <= cnt_in;
        argmax  <= idx;
        tie     <= 1'b0;
      end else if (cnt_in == max_val) begin
        tie <= 1'b1;
      end
      if (done) busy <= 1'b0;
      else      idx  <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vote_tally_engine.sv
// rtl/vote_tally_engine.sv - one-hot ballot counter with sequential winner scan
// Optional voter lockout bitmap enabled by defining VOTER_LOCKOUT_EN.
module vote_tally_engine #(
  parameter int N_CAND   = 4,
  parameter int CNT_W    = 12,
  parameter int N_VOTERS = 16,
  localparam int IDX_W   = $clog2(N_CAND),
  localparam int VID_W   = $clog2(N_VOTERS),
  localparam int TOT_W   = CNT_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_open,
  input  logic              cmd_close,
  input  logic              cmd_clear,
  input  logic              vote_valid,
  input  logic [N_CAND-1:0] vote_sel,
  input  logic [VID_W-1:0]  voter_id,
  output logic              vote_ready,
  output logic              vote_ack,
  output logic              vote_nak,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_count,
  output logic [TOT_W-1:0]  total_votes,
  output logic [N_CAND-1:0] winner_onehot,
  output logic              tie,
  output logic              result_valid,
  output logic [1:0]        state
);
  import vote_pkg::*;

  vote_state_t state_q, state_n;
  logic [CNT_W-1:0] counts [N_CAND];
  logic [IDX_W-1:0] sel_idx, scan_idx, scan_argmax;
  logic [CNT_W-1:0] scan_cnt, scan_max, rd_mux;
  logic             xfer, accept, locked, scan_start, scan_done, scan_tie;

  assign state        = state_q;
  assign vote_ready   = (state_q == ST_OPEN) && !cmd_clear;
  assign xfer         = vote_valid && vote_ready;
  assign accept       = xfer && $onehot(vote_sel) && (counts[sel_idx] != '1) && !locked;
  assign scan_start   = (state_q == ST_OPEN) && cmd_close && !cmd_clear;
  assign result_valid = (state_q == ST_RESULT);

  always_comb begin
    sel_idx  = '0;
    scan_cnt = '0;
    rd_mux   = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (vote_sel[i])                 sel_idx  = IDX_W'(i);
      if (scan_idx == IDX_W'(i))       scan_cnt = counts[i];
      if (rd_idx == IDX_W'(i))         rd_mux   = counts[i];
    end
  end

`ifdef VOTER_LOCKOUT_EN
  logic [N_VOTERS-1:0] voted;
  assign locked = voted[voter_id];
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            voted <= '0;
    else if (cmd_clear) voted <= '0;
    else if (accept)    voted[voter_id] <= 1'b1;
  end
`else
  logic unused_voter_id;
  assign locked          = 1'b0;
  assign unused_voter_id = ^voter_id;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CAND; i++) counts[i] <= '0;
      total_votes <= '0;
      vote_ack    <= 1'b0;
      vote_nak    <= 1'b0;
      rd_count    <= '0;
    end else begin
      vote_ack <= accept;
      vote_nak <= xfer && !accept;
      rd_count <= rd_mux;
      if (cmd_clear) begin
        for (int i = 0; i < N_CAND; i++) counts[i] <= '0;
        total_votes <= '0;
      end else if (accept) begin
        counts[sel_idx] <= counts[sel_idx] + CNT_W'(1);
        total_votes     <= total_votes + TOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_open)  state_n = ST_OPEN;
      ST_OPEN:   if (cmd_close) state_n = ST_TALLY;
      ST_TALLY:  if (scan_done) state_n = ST_RESULT;
      ST_RESULT: if (cmd_open)  state_n = ST_OPEN;
      default:                  state_n = ST_IDLE;
    endcase
    if (cmd_clear) state_n = ST_IDLE;
  end

  vote_max_scan #(.N_CAND(N_CAND), .CNT_W(CNT_W)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmd_clear),
    .start   (scan_start),
    .cnt_in  (scan_cnt),
    .idx     (scan_idx),
    .done    (scan_done),
    .argmax  (scan_argmax),
    .max_val (scan_max),
    .tie     (scan_tie)
  );

  // A zero maximum means no ballots: neither a winner nor a tie.
  always_comb begin
    winner_onehot = '0;
    tie           = result_valid && (scan_max != '0) && scan_tie;
    if (result_valid && (scan_max != '0) && !scan_tie) winner_onehot[scan_argmax] = 1'b1;
  end

endmodule
